// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the data-memory path.
//   - funct3 encodings for loads and stores (stores share the load codes)
//   - lsu_state_t: LSU control FSM states
//   - byte-mask bases and helpers for access sizing / misalignment
package npc_pkg;

    localparam logic [2:0] Funct3Lb  = 3'd0;
    localparam logic [2:0] Funct3Lh  = 3'd1;
    localparam logic [2:0] Funct3Lw  = 3'd2;
    localparam logic [2:0] Funct3Lbu = 3'd4;
    localparam logic [2:0] Funct3Lhu = 3'd5;
    localparam logic [2:0] Funct3Sb  = 3'd0;
    localparam logic [2:0] Funct3Sh  = 3'd1;
    localparam logic [2:0] Funct3Sw  = 3'd2;

    localparam logic [7:0] MaskByte = 8'h01;
    localparam logic [7:0] MaskHalf = 8'h03;
    localparam logic [7:0] MaskWord = 8'h0F;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_t;

    // Unlisted funct3 codes size as a word.
    function automatic logic [7:0] base_mask(input logic [2:0] op);
        logic [7:0] m;
        case (op)
            Funct3Lb, Funct3Lbu: m = MaskByte;
            Funct3Lh, Funct3Lhu: m = MaskHalf;
            default:             m = MaskWord;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            Funct3Lb, Funct3Lbu: mis = 1'b0;
            Funct3Lh, Funct3Lhu: mis = off[0];
            default:             mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: moves the addressed lane of an sram word down to bit 0,
// truncates to the access size and sign/zero extends it.
//   data  in 32 : raw sram read word
//   op    in 3  : load funct3 (unlisted codes behave as LW)
//   off   in 2  : byte offset within the word
//   rdata out 32: extended load result
module lsu_load_align
    import npc_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        // Lanes above byte 3 fall off the end; no wrap-around.
        shifted = data >> {off, 3'b000};
        case (op)
            Funct3Lb:  rdata = {{24{shifted[7]}}, shifted[7:0]};
            Funct3Lh:  rdata = {{16{shifted[15]}}, shifted[15:0]};
            Funct3Lbu: rdata = {24'h0, shifted[7:0]};
            Funct3Lhu: rdata = {16'h0, shifted[15:0]};
            default:   rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit in front of the data sram.
// Accepts one op from execute (in_valid/in_ready), issues a one-cycle sram
// strobe, waits for read data if needed and presents the result to
// write-back (out_valid/out_ready).
//   clk, rst (sync, active-high)
//   in_*   : execute-side request (valid, ready, ren, wen, op, addr, wdata)
//   out_*  : write-back result (valid, ready, rdata, err)
//   sram_* : sram request (ren, wen, wmask, addr, wdata) and response
//            (data, valid, receive_valid)
// Build option: define LSU_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses (no sram strobe, out_err=1). Otherwise out_err stays 0.
module lsu
    import npc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        sram_ren,
    output logic        sram_wen,
    output logic [7:0]  sram_wmask,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_data,
    input  logic        sram_valid,
    output logic        sram_receive_valid
);

    lsu_state_t  state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wen_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;
    logic        misalign;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (in_ren || in_wen) && is_misaligned(in_op, in_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state_q == StIdle) && in_valid;

    lsu_load_align u_load_align (
        .data  (sram_data),
        .op    (op_q),
        .off   (addr_q[1:0]),
        .rdata (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wen_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                op_q    <= in_op;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                wen_q   <= in_wen;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        rdata_d            = rdata_q;
        err_d              = err_q;
        in_ready           = 1'b0;
        out_valid          = 1'b0;
        out_rdata          = 32'd0;
        out_err            = 1'b0;
        sram_ren           = 1'b0;
        sram_wen           = 1'b0;
        sram_wmask         = 8'd0;
        sram_addr          = 32'd0;
        sram_wdata         = 32'd0;
        sram_receive_valid = 1'b0;

        // Request pins are only live while the access is in flight.
        if (state_q == StReq || state_q == StWait) begin
            sram_addr  = {addr_q[31:2], 2'b00};
            sram_wmask = base_mask(op_q) << addr_q[1:0];
            sram_wdata = wdata_q << {addr_q[1:0], 3'b000};
        end

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rdata_d = 32'd0;
                    err_d   = misalign;
                    if (misalign || (!in_ren && !in_wen)) begin
                        state_d = StResp;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                // Store wins when both ren and wen were requested.
                if (wen_q) begin
                    sram_wen = 1'b1;
                    state_d  = StResp;
                end else begin
                    sram_ren = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (sram_valid) begin
                    sram_receive_valid = 1'b1;
                    rdata_d            = load_data;
                    state_d            = StResp;
                end
            end
            StResp: begin
                out_valid = 1'b1;
                out_rdata = rdata_q;
                out_err   = err_q;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed-vector bench for lsu. The bench plays both execute/
// write-back and the sram, samples 1ns after each rising edge and checks
// against hand-computed values.
module tb_lsu;
    import npc_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ren;
    logic        in_wen;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        sram_ren;
    logic        sram_wen;
    logic [7:0]  sram_wmask;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_data;
    logic        sram_valid;
    logic        sram_receive_valid;

    int n_vec = 0;
    int n_bad = 0;

    lsu dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_ren             (in_ren),
        .in_wen             (in_wen),
        .in_op              (in_op),
        .in_addr            (in_addr),
        .in_wdata           (in_wdata),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_rdata          (out_rdata),
        .out_err            (out_err),
        .sram_ren           (sram_ren),
        .sram_wen           (sram_wen),
        .sram_wmask         (sram_wmask),
        .sram_addr          (sram_addr),
        .sram_wdata         (sram_wdata),
        .sram_data          (sram_data),
        .sram_valid         (sram_valid),
        .sram_receive_valid (sram_receive_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":ctl"}, {26'd0, in_ready, out_valid, out_err, sram_ren, sram_wen,
                              sram_receive_valid}, 32'h20);
        check({tag, ":rdata"}, out_rdata, 32'd0);
        check({tag, ":wmask"}, {24'd0, sram_wmask}, 32'd0);
        check({tag, ":addr"}, sram_addr, 32'd0);
        check({tag, ":wdata"}, sram_wdata, 32'd0);
    endtask

    // One complete operation starting from IDLE; hold = cycles out_ready stays low in RESP.
    task automatic run_op(input string tag, input logic ren, input logic wen,
                          input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] sd, input logic [31:0] exp_rd,
                          input logic [7:0] exp_mask, input logic [31:0] exp_wd,
                          input int hold);
        in_valid  = 1'b1;
        in_ren    = ren;
        in_wen    = wen;
        in_op     = op;
        in_addr   = addr;
        in_wdata  = wd;
        out_ready = (hold == 0);
        check({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_ren   = 1'b0;
        in_wen   = 1'b0;
        if (ren || wen) begin
            check({tag, ":req_addr"}, sram_addr, {addr[31:2], 2'b00});
            check({tag, ":req_out_valid"}, {31'd0, out_valid}, 32'd0);
            if (wen) begin
                check({tag, ":req_strobe"}, {30'd0, sram_ren, sram_wen}, 32'd1);
                check({tag, ":wmask"}, {24'd0, sram_wmask}, {24'd0, exp_mask});
                check({tag, ":wdata"}, sram_wdata, exp_wd);
                step();
            end else begin
                check({tag, ":req_strobe"}, {30'd0, sram_ren, sram_wen}, 32'd2);
                check({tag, ":req_rcv"}, {31'd0, sram_receive_valid}, 32'd0);
                sram_valid = 1'b1;
                sram_data  = sd;
                step();
                check({tag, ":wait_rcv"}, {31'd0, sram_receive_valid}, 32'd1);
                check({tag, ":wait_strobe"}, {30'd0, sram_ren, sram_wen}, 32'd0);
                check({tag, ":wait_addr"}, sram_addr, {addr[31:2], 2'b00});
                step();
                sram_valid = 1'b0;
                sram_data  = 32'd0;
            end
        end
        for (int i = 0; i <= hold; i++) begin
            check({tag, ":resp_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ":resp_rdata"}, out_rdata, exp_rd);
            check({tag, ":resp_err"}, {31'd0, out_err}, 32'd0);
            check({tag, ":resp_side"}, {29'd0, in_ready, sram_ren, sram_wen}, 32'd0);
            if (i == hold) out_ready = 1'b1;
            step();
        end
        check({tag, ":idle_ready"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_ren     = 1'b0;
        in_wen     = 1'b0;
        in_op      = 3'd0;
        in_addr    = 32'd0;
        in_wdata   = 32'd0;
        out_ready  = 1'b1;
        sram_data  = 32'd0;
        sram_valid = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        run_op("lw", 1'b1, 1'b0, Funct3Lw, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 8'h00, 32'd0, 0);
        run_op("lb", 1'b1, 1'b0, Funct3Lb, 32'h8000_0003, 32'd0, 32'h8000_0000,
               32'hFFFF_FF80, 8'h00, 32'd0, 0);
        run_op("lbu", 1'b1, 1'b0, Funct3Lbu, 32'h8000_0003, 32'd0, 32'h8000_0000,
               32'h0000_0080, 8'h00, 32'd0, 0);
        run_op("lh", 1'b1, 1'b0, Funct3Lh, 32'h8000_0002, 32'd0, 32'hABCD_1234,
               32'hFFFF_ABCD, 8'h00, 32'd0, 0);
        run_op("lhu", 1'b1, 1'b0, Funct3Lhu, 32'h8000_0002, 32'd0, 32'hABCD_1234,
               32'h0000_ABCD, 8'h00, 32'd0, 0);
        run_op("sh", 1'b0, 1'b1, Funct3Sh, 32'h8000_0002, 32'h0000_1234, 32'd0,
               32'd0, 8'h0C, 32'h1234_0000, 0);
        run_op("sb", 1'b0, 1'b1, Funct3Sb, 32'h8000_0001, 32'h0000_00AB, 32'd0,
               32'd0, 8'h02, 32'h0000_AB00, 0);
        run_op("both", 1'b1, 1'b1, Funct3Sw, 32'h8000_0010, 32'hCAFE_F00D, 32'd0,
               32'd0, 8'h0F, 32'hCAFE_F00D, 0);
        run_op("noop", 1'b0, 1'b0, Funct3Lw, 32'h0000_1234, 32'd0, 32'd0,
               32'd0, 8'h00, 32'd0, 0);
        run_op("hold", 1'b1, 1'b0, Funct3Lw, 32'h8000_0020, 32'd0, 32'h1357_9BDF,
               32'h1357_9BDF, 8'h00, 32'd0, 5);

        // Reset while parked in WAIT.
        in_valid = 1'b1;
        in_ren   = 1'b1;
        in_op    = Funct3Lw;
        in_addr  = 32'h8000_0008;
        step();
        in_valid = 1'b0;
        in_ren   = 1'b0;
        check("rstwait:req", {30'd0, sram_ren, sram_wen}, 32'd2);
        step();
        check("rstwait:wait_addr", sram_addr, 32'h8000_0008);
        check("rstwait:wait_rcv", {31'd0, sram_receive_valid}, 32'd0);
        step();
        check("rstwait:still_wait", {30'd0, out_valid, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        check_reset_outputs("rstwait");
        rst = 1'b0;
        run_op("after_rst", 1'b1, 1'b0, Funct3Lw, 32'h8000_000C, 32'd0, 32'h0BAD_F00D,
               32'h0BAD_F00D, 8'h00, 32'd0, 0);

`ifdef LSU_MISALIGN_CHECK_EN
        in_valid = 1'b1;
        in_ren   = 1'b1;
        in_op    = Funct3Lw;
        in_addr  = 32'h8000_0001;
        step();
        in_valid = 1'b0;
        in_ren   = 1'b0;
        check("mis:strobe", {30'd0, sram_ren, sram_wen}, 32'd0);
        check("mis:valid_err", {30'd0, out_valid, out_err}, 32'd3);
        check("mis:rdata", out_rdata, 32'd0);
        step();
        check("mis:idle", {30'd0, in_ready, out_valid}, 32'd2);
`else
        run_op("lw_off1", 1'b1, 1'b0, Funct3Lw, 32'h8000_0001, 32'd0, 32'hDEAD_BEEF,
               32'h00DE_ADBE, 8'h00, 32'd0, 0);
        run_op("sw_off3", 1'b0, 1'b1, Funct3Sw, 32'h8000_0003, 32'h1122_3344, 32'd0,
               32'd0, 8'h78, 32'h4400_0000, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
